// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Start/busy/done handshake; result and overflow flag held until the next done.
module bin_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int W  = 4*DIGITS + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    logic [0:0]          state_q, state_d;
    logic [W-1:0]        work_q, work_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [W-1:0]        adj;
    logic [W-1:0]        shifted;
    logic                out_bit;

    // Add-3 on every digit >= 5; the bit leaving the top digit stands for 10^DIGITS
    always_comb begin
        adj = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[BIN_W+4*k +: 4] >= 4'd5) begin
                adj[BIN_W+4*k +: 4] = work_q[BIN_W+4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj[W-2:0], 1'b0};
        out_bit = adj[W-1];
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SHIFT;
                    work_d    = {{(4*DIGITS){1'b0}}, binary};
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                end
            end
            S_SHIFT: begin
                work_d    = shifted;
                cnt_d     = cnt_q + CW'(1);
                ovf_acc_d = ovf_acc_q | out_bit;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    bcd_d   = shifted[W-1 -: 4*DIGITS];
                    ovf_d   = ovf_acc_q | out_bit;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q == S_SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Bench for bin_bcd_seq: three instances (16/5, 8/3, 8/2) against a
// countdown-plus-decimal-arithmetic model, with directed literal checks.
module tb_bin_bcd_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start;
    logic [15:0] bin [3];

    logic [2:0]  o_busy, o_done, o_ovf;
    logic [19:0] bcd0;
    logic [11:0] bcd1;
    logic [7:0]  bcd2;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    bin_bcd_seq #(.BIN_W(16), .DIGITS(5)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .binary(bin[0]),
        .busy(o_busy[0]), .done(o_done[0]), .bcd(bcd0), .overflow(o_ovf[0])
    );
    bin_bcd_seq #(.BIN_W(8), .DIGITS(3)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .binary(bin[1][7:0]),
        .busy(o_busy[1]), .done(o_done[1]), .bcd(bcd1), .overflow(o_ovf[1])
    );
    bin_bcd_seq #(.BIN_W(8), .DIGITS(2)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .binary(bin[2][7:0]),
        .busy(o_busy[2]), .done(o_done[2]), .bcd(bcd2), .overflow(o_ovf[2])
    );

    function automatic int bw(int i);
        return (i == 0) ? 16 : 8;
    endfunction

    function automatic int dg(int i);
        return (i == 0) ? 5 : ((i == 1) ? 3 : 2);
    endfunction

    function automatic logic [19:0] get_bcd(int i);
        if (i == 0) return bcd0;
        if (i == 1) return {8'd0, bcd1};
        return {12'd0, bcd2};
    endfunction

    // Decimal digits of v mod 10^d, one nibble per digit
    function automatic logic [19:0] dec(int unsigned v, int d);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic too_big(int unsigned v, int d);
        int unsigned p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return v >= p;
    endfunction

    int          m_rem  [3];
    int unsigned m_val  [3];
    logic [19:0] m_bcd  [3];
    logic        m_ovf  [3];
    logic        m_done [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_rem[i]  <= 0;
                m_val[i]  <= 0;
                m_bcd[i]  <= '0;
                m_ovf[i]  <= 1'b0;
                m_done[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_done[i] <= 1'b0;
                if (m_rem[i] > 0) begin
                    m_rem[i] <= m_rem[i] - 1;
                    if (m_rem[i] == 1) begin
                        m_bcd[i]  <= dec(m_val[i], dg(i));
                        m_ovf[i]  <= too_big(m_val[i], dg(i));
                        m_done[i] <= 1'b1;
                    end
                end else if (start[i]) begin
                    m_val[i] <= (i == 0) ? 32'(bin[i]) : 32'(bin[i][7:0]);
                    m_rem[i] <= bw(i);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Every cycle: compare all instances against the model
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.busy", i), 32'(o_busy[i]),
                    32'(m_rem[i] != 0));
                chk($sformatf("u%0d.done", i), 32'(o_done[i]),
                    32'(m_done[i]));
                chk($sformatf("u%0d.bcd", i), 32'(get_bcd(i)),
                    32'(m_bcd[i]));
                chk($sformatf("u%0d.ovf", i), 32'(o_ovf[i]),
                    32'(m_ovf[i]));
            end
        end
    endtask

    task automatic run(input int i, input int unsigned v,
                       input logic [19:0] eb, input logic eo);
        int cyc;
        int bc;
        start[i] = 1'b1;
        bin[i]   = 16'(v);
        tick();
        start[i] = 1'b0;
        cyc = 0;
        bc  = o_busy[i] ? 1 : 0;
        while (!o_done[i] && cyc < 100) begin
            tick();
            cyc++;
            if (o_busy[i]) bc++;
        end
        chk($sformatf("u%0d.latency(%0d)", i, v), cyc, bw(i));
        chk($sformatf("u%0d.busy_cycles(%0d)", i, v), bc, bw(i));
        chk($sformatf("u%0d.bcd_lit(%0d)", i, v), 32'(get_bcd(i)), 32'(eb));
        chk($sformatf("u%0d.ovf_lit(%0d)", i, v), 32'(o_ovf[i]), 32'(eo));
        tick();
        chk($sformatf("u%0d.done_single(%0d)", i, v), 32'(o_done[i]), 0);
    endtask

    initial begin
        int nd;
        int cyc;
        logic [19:0] cap;

        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 3; i++) bin[i] = '0;
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset.busy", 32'(o_busy), 0);
        chk("reset.done", 32'(o_done), 0);
        chk("reset.bcd0", 32'(bcd0), 0);
        chk("reset.ovf", 32'(o_ovf), 0);
        rst = 1'b0;
        tick();

        run(0, 0, 20'h00000, 1'b0);
        run(0, 65535, 20'h65535, 1'b0);
        run(1, 255, 20'h00255, 1'b0);
        run(2, 255, 20'h00055, 1'b1);
        run(2, 99, 20'h00099, 1'b0);
        run(1, 7, 20'h00007, 1'b0);

        // Start pulsed while busy must be ignored
        start[0] = 1'b1;
        bin[0]   = 16'd1234;
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        start[0] = 1'b1;
        bin[0]   = 16'd9999;
        tick();
        start[0] = 1'b0;
        nd  = 0;
        cap = '0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (o_done[0]) begin
                nd++;
                cap = bcd0;
            end
        end
        chk("ignore.done_count", nd, 1);
        chk("ignore.bcd", 32'(cap), 32'h01234);

        // Reset mid-conversion aborts it
        start[0] = 1'b1;
        bin[0]   = 16'd4321;
        tick();
        start[0] = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        chk("abort.busy", 32'(o_busy[0]), 0);
        chk("abort.bcd", 32'(bcd0), 0);
        rst = 1'b0;
        nd  = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (o_done[0]) nd++;
        end
        chk("abort.no_done", nd, 0);
        run(0, 42, 20'h00042, 1'b0);

        // Back-to-back with start held high
        start[0] = 1'b1;
        bin[0]   = 16'd100;
        cyc = 0;
        tick();
        while (!o_done[0] && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("b2b.first_bcd", 32'(bcd0), 32'h00100);
        bin[0] = 16'd7;
        cyc = 0;
        tick();
        cyc++;
        while (!o_done[0] && cyc < 100) begin
            tick();
            cyc++;
        end
        start[0] = 1'b0;
        chk("b2b.gap", cyc, 17);
        chk("b2b.second_bcd", 32'(bcd0), 32'h00007);
        repeat (20) tick();
        chk("b2b.idle_after", 32'(o_busy[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
